// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable bit divider, sticky error flags.
// Read data is combinational from sel/bus_addr; writes land on the closing clock edge.
//
// state    | meaning (shared by TX and RX FSMs)
// ST_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// ST_START | start bit in progress (RX: half-bit wait, then glitch check)
// ST_DATA  | 8 data bits, LSB first
// ST_STOP  | stop bit; RX decides push / overrun / frame error here
module bus_uart #(
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 4,
  parameter int DIV_RESET = 867
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic        wr_cyc, rd_cyc;
  logic [15:0] divider;
  logic        rx_overrun, tx_drop, rx_frame_err;
  logic        unused_ok;

  assign wr_cyc    = sel && (bus_mask_w != 4'b0000);
  assign rd_cyc    = sel && (bus_mask_w == 4'b0000);
  assign unused_ok = &{1'b0, bus_data_w[31:16]};

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TPW-1:0] tx_wptr, tx_rptr;
  logic [TCW-1:0] tx_count;
  logic           tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_drop_evt;

  assign tx_full     = (tx_count == TX_FULL_CNT);
  assign tx_empty    = (tx_count == '0);
  assign tx_push_req = wr_cyc && (bus_addr == 2'd0) && bus_mask_w[0];
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop_evt = tx_push_req && tx_full;

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wptr] <= bus_data_w[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TPW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TPW'(1);
      tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_line_n;
  logic        tx_busy;

  assign tx_busy = (tx_state != ST_IDLE);
  assign uart_tx = tx_line;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    tx_line_n  = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rptr];
          tx_cnt_n   = divider;
          tx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n   = divider;
          tx_idx_n   = 3'd0;
          tx_state_n = ST_DATA;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = divider;
          if (tx_idx == 3'd7) begin
            tx_state_n = ST_STOP;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt == 16'd0) tx_state_n = ST_IDLE;
        else                 tx_cnt_n   = tx_cnt - 16'd1;
      end
      default: tx_state_n = ST_IDLE;
    endcase
    // Line is registered from the next state so uart_tx never glitches.
    case (tx_state_n)
      ST_START: tx_line_n = 1'b0;
      ST_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // ---------------- RX synchronizer and FSM ----------------
  logic        rx_s1, rx_s2, rx_prev;
  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done, rx_frame_evt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_done      = 1'b0;
    rx_frame_evt = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_n   = divider >> 1;
          rx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt == 16'd0) begin
          if (!rx_s2) begin
            rx_cnt_n   = divider;
            rx_idx_n   = 3'd0;
            rx_state_n = ST_DATA;
          end else begin
            rx_state_n = ST_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = divider;
          if (rx_idx == 3'd7) rx_state_n = ST_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_state_n   = ST_IDLE;
          rx_done      = rx_s2;
          rx_frame_evt = !rx_s2;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RPW-1:0] rx_wptr, rx_rptr;
  logic [RCW-1:0] rx_count;
  logic           rx_full, rx_valid, rx_push, rx_pop, rx_overrun_evt;

  assign rx_full        = (rx_count == RX_FULL_CNT);
  assign rx_valid       = (rx_count != '0);
  assign rx_push        = rx_done && !rx_full;
  assign rx_overrun_evt = rx_done && rx_full;
  assign rx_pop         = rd_cyc && (bus_addr == 2'd1) && rx_valid;

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RPW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RPW'(1);
      rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  // ---------------- Registers and flags ----------------
  logic status_wr, div_wr;

  assign status_wr = wr_cyc && (bus_addr == 2'd2) && bus_mask_w[0];
  assign div_wr    = wr_cyc && (bus_addr == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      divider      <= 16'(DIV_RESET);
      rx_overrun   <= 1'b0;
      tx_drop      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (div_wr && bus_mask_w[0]) divider[7:0]  <= bus_data_w[7:0];
      if (div_wr && bus_mask_w[1]) divider[15:8] <= bus_data_w[15:8];
      // A new event wins over a same-cycle clear.
      rx_overrun   <= (rx_overrun   && !(status_wr && bus_data_w[4])) || rx_overrun_evt;
      tx_drop      <= (tx_drop      && !(status_wr && bus_data_w[5])) || tx_drop_evt;
      rx_frame_err <= (rx_frame_err && !(status_wr && bus_data_w[6])) || rx_frame_evt;
    end
  end

  always_comb begin
    bus_data_r = '0;
    if (sel) begin
      case (bus_addr)
        2'd1: if (rx_valid) bus_data_r = {1'b1, 23'b0, rx_mem[rx_rptr]};
        2'd2: bus_data_r = {25'b0, rx_frame_err, tx_drop, rx_overrun,
                            tx_busy, rx_valid, tx_empty, tx_full};
        2'd3: bus_data_r = {16'b0, divider};
        default: bus_data_r = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: bus register access, TX/RX framing,
// FIFO limits, sticky flags and reset behaviour against a queue-based model.
module tb_bus_uart;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_data_w = 32'd0;
  logic [3:0]  bus_mask_w = 4'd0;
  wire  [31:0] bus_data_r;
  logic        uart_rx = 1'b1;
  wire         uart_tx;

  int checks = 0;
  int errors = 0;
  int bit_clks = 4;
  logic [7:0] mon_q[$];
  logic [7:0] mon_b;
  int mon_bad_stop = 0;

  bus_uart #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_RESET(867)) dut (
    .clock(clock), .reset(reset), .sel(sel), .bus_addr(bus_addr),
    .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w), .bus_data_r(bus_data_r),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Line decoder: finds a start bit, samples mid-bit at the current bit period.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && uart_tx === 1'b0) begin
        repeat (bit_clks / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clock);
          mon_b[i] = uart_tx;
        end
        repeat (bit_clks) @(negedge clock);
        if (uart_tx !== 1'b1) mon_bad_stop++;
        mon_q.push_back(mon_b);
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    sel = 1'b1; bus_addr = a; bus_data_w = d; bus_mask_w = m;
    @(posedge clock); #1;
    sel = 1'b0; bus_mask_w = 4'd0;
  endtask

  // Combinational look without crossing a clock edge (no pop side effect).
  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; bus_addr = a; bus_mask_w = 4'd0;
    #1;
    d = bus_data_r;
    sel = 1'b0;
  endtask

  task automatic rx_read(output logic [31:0] d);
    @(negedge clock);
    sel = 1'b1; bus_addr = 2'd1; bus_mask_w = 4'd0;
    #1;
    d = bus_data_r;
    @(posedge clock); #1;
    sel = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int clks);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      uart_rx = f[i];
      repeat (clks - 1) @(negedge clock);
    end
    @(negedge clock);
    uart_rx = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic set_div(input int div);
    bus_write(2'd3, 32'(div), 4'b0011);
    bit_clks = div + 1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    peek(2'd2, d);
    checks++; if (d !== 32'h2) $display("FAIL reset_status got %h want %h", d, 32'h2);
    if (d !== 32'h2) errors++;
    peek(2'd3, d);
    checks++; if (d !== 32'd867) begin errors++; $display("FAIL reset_divider got %h want %h", d, 32'd867); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    peek(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rxdata got %h want 0", d); end
    peek(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got %h want 0", d); end
  endtask

  task automatic test_divider();
    logic [31:0] d;
    bus_write(2'd3, 32'hFFFF0003, 4'b1111);
    @(posedge clock); #1; peek(2'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL div_full got %h want %h", d, 32'h3); end
    bus_write(2'd3, 32'h000012FF, 4'b0010);
    peek(2'd3, d);
    checks++; if (d !== 32'h1203) begin errors++; $display("FAIL div_hi_byte got %h want %h", d, 32'h1203); end
    bus_write(2'd3, 32'h00000000, 4'b0010);
    peek(2'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL div_hi_clear got %h want %h", d, 32'h3); end
    bit_clks = 4;
  endtask

  task automatic test_tx_basic();
    logic [9:0] frame;
    logic [31:0] d;
    frame = {1'b1, 8'h55, 1'b0};
    repeat (4) @(posedge clock);
    bus_write(2'd0, 32'h00000055, 4'b0001);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_latency got %b want 1", uart_tx); end
    @(posedge clock); #1;
    for (int j = 0; j < 40; j++) begin
      checks++;
      if (uart_tx !== frame[j / 4]) begin
        errors++; $display("FAIL tx_bit[%0d] got %b want %b", j, uart_tx, frame[j / 4]);
      end
      if (j == 39) begin
        peek(2'd2, d);
        checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL tx_busy_end got %b want 1", d[3]); end
      end
      @(posedge clock); #1;
    end
    peek(2'd2, d);
    checks++; if (d[3] !== 1'b0) begin errors++; $display("FAIL tx_busy_off got %b want 0", d[3]); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle got %b want 1", uart_tx); end
    repeat (4) @(posedge clock);
    mon_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [31:0] d;
    mon_q.delete(); mon_bad_stop = 0;
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(2'd0, {24'd0, b}, 4'b0001);
    repeat (3) @(posedge clock);
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (i < TX_DEPTH) exp_q.push_back(b);
      bus_write(2'd0, {24'd0, b}, 4'b0001);
    end
    peek(2'd2, d);
    checks++; if (d[5] !== 1'b1) begin errors++; $display("FAIL b2b_drop got %b want 1", d[5]); end
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL b2b_full got %b want 1", d[0]); end
    for (int i = 0; i < 9 * 41 + 100 && mon_q.size() < exp_q.size(); i++) @(posedge clock);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", mon_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h want %h", i, mon_q[i], exp_q[i]); end
      end
    end
    checks++; if (mon_bad_stop != 0) begin errors++; $display("FAIL b2b_stop got %0d want 0", mon_bad_stop); end
    repeat (10) @(posedge clock);
    bus_write(2'd2, 32'h20, 4'b0001);
    peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_clear got %h want %h", d, 32'h2); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    send_rx(8'hA3, 1'b1, 4);
    #1; peek(2'd2, d);
    checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL rx_valid got %b want 1", d[2]); end
    rx_read(d);
    checks++; if (d !== 32'h800000A3) begin errors++; $display("FAIL rx_data got %h want %h", d, 32'h800000A3); end
    rx_read(d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty got %h want 0", d); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] q[$];
    logic [7:0] b;
    logic [31:0] d, e;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (q.size() < RX_DEPTH) q.push_back(b);
      send_rx(b, 1'b1, 4);
    end
    #1; peek(2'd2, d);
    checks++; if (d[4] !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", d[4]); end
    for (int i = 0; i < RX_DEPTH + 1; i++) begin
      e = (q.size() > 0) ? {1'b1, 23'd0, q.pop_front()} : 32'd0;
      rx_read(d);
      checks++; if (d !== e) begin errors++; $display("FAIL ovr_read[%0d] got %h want %h", i, d, e); end
    end
    bus_write(2'd2, 32'h10, 4'b0001);
    peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovr_clear got %h want %h", d, 32'h2); end
  endtask

  task automatic test_rx_frame_err();
    logic [31:0] d;
    send_rx(8'($urandom), 1'b0, 4);
    #1; peek(2'd2, d);
    checks++; if (d[6] !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", d[6]); end
    checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL ferr_nopush got %b want 0", d[2]); end
    bus_write(2'd2, 32'h40, 4'b0001);
    peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ferr_clear got %h want %h", d, 32'h2); end
  endtask

  task automatic test_rx_glitch();
    logic [31:0] d;
    logic [7:0] b;
    @(negedge clock); uart_rx = 1'b0;
    @(negedge clock); uart_rx = 1'b1;
    repeat (12) @(negedge clock);
    #1; peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL glitch_status got %h want %h", d, 32'h2); end
    b = 8'($urandom);
    send_rx(b, 1'b1, 4);
    rx_read(d);
    checks++; if (d !== {1'b1, 23'd0, b}) begin errors++; $display("FAIL glitch_next got %h want %h", d, {1'b1, 23'd0, b}); end
  endtask

  task automatic test_random();
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] b;
    logic [31:0] d, e;
    logic ovr, ferr, stop_bit;
    int div;
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(3, 9);
      set_div(div);
      mon_q.delete(); mon_bad_stop = 0; txq.delete();
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom);
        txq.push_back(b);
        bus_write(2'd0, {24'd0, b}, 4'b0001);
      end
      for (int i = 0; i < 3 * 10 * (div + 2) + 60 && mon_q.size() < 3; i++) @(posedge clock);
      checks++;
      if (mon_q.size() != 3) begin
        errors++; $display("FAIL rnd_tx_count[%0d] got %0d want 3", r, mon_q.size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (mon_q[i] !== txq[i]) begin errors++; $display("FAIL rnd_tx[%0d.%0d] got %h want %h", r, i, mon_q[i], txq[i]); end
        end
      end
      checks++; if (mon_bad_stop != 0) begin errors++; $display("FAIL rnd_tx_stop got %0d want 0", mon_bad_stop); end
      repeat (2 * (div + 1)) @(posedge clock);
      rxq.delete(); ovr = 1'b0; ferr = 1'b0;
      for (int i = 0; i < 6; i++) begin
        b = 8'($urandom);
        stop_bit = ($urandom_range(0, 3) != 0);
        if (!stop_bit)                 ferr = 1'b1;
        else if (rxq.size() < RX_DEPTH) rxq.push_back(b);
        else                           ovr = 1'b1;
        send_rx(b, stop_bit, div + 1);
      end
      #1; peek(2'd2, d);
      e = {25'd0, ferr, 1'b0, ovr, 1'b0, (rxq.size() > 0), 1'b1, 1'b0};
      checks++; if (d !== e) begin errors++; $display("FAIL rnd_status[%0d] got %h want %h", r, d, e); end
      for (int i = 0; i < RX_DEPTH + 1; i++) begin
        e = (rxq.size() > 0) ? {1'b1, 23'd0, rxq.pop_front()} : 32'd0;
        rx_read(d);
        checks++; if (d !== e) begin errors++; $display("FAIL rnd_rx[%0d.%0d] got %h want %h", r, i, d, e); end
      end
      bus_write(2'd2, 32'h70, 4'b0001);
      peek(2'd2, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL rnd_clear[%0d] got %h want %h", r, d, 32'h2); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    set_div(3);
    for (int i = 0; i < 3; i++) bus_write(2'd0, 32'($urandom_range(0, 255)), 4'b0001);
    repeat (12) @(posedge clock); #1;
    peek(2'd2, d);
    checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", d[3]); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_tx got %b want 1", uart_tx); end
    peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mid_status got %h want %h", d, 32'h2); end
    @(negedge clock); reset = 1'b0;
    #1; peek(2'd3, d);
    checks++; if (d !== 32'd867) begin errors++; $display("FAIL mid_divider got %h want %h", d, 32'd867); end
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (uart_tx !== 1'b1) begin
        errors++; $display("FAIL mid_quiet got %b want 1 at cycle %0d", uart_tx, i);
        break;
      end
    end
    checks++;
    peek(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mid_status_end got %h want %h", d, 32'h2); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_tx_basic();
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_rx_frame_err();
    test_rx_glitch();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
